// File: rtl/seg_dec_pkg.sv
// Shared constants and types for the seven-segment frame decoder.
// Patterns are active-low: bit0=a ... bit6=g, bit7=dp (dp=1 means the point is off).
package seg_dec_pkg;

   localparam logic [7:0] SEG_BLANK = 8'hFF;
   localparam logic [7:0] SEG_MINUS = 8'hBF;

   localparam logic [7:0] SEG_D0 = 8'hC0;
   localparam logic [7:0] SEG_D1 = 8'hF9;
   localparam logic [7:0] SEG_D2 = 8'hA4;
   localparam logic [7:0] SEG_D3 = 8'hB0;
   localparam logic [7:0] SEG_D4 = 8'h99;
   localparam logic [7:0] SEG_D5 = 8'h92;
   localparam logic [7:0] SEG_D6 = 8'h82;
   localparam logic [7:0] SEG_D7 = 8'hF8;
   localparam logic [7:0] SEG_D8 = 8'h80;
   localparam logic [7:0] SEG_D9 = 8'h90;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] COLLECT = 2'd1;
   localparam logic [1:0] DONE    = 2'd2;

   typedef enum logic [1:0] {
      PK_DIGIT   = 2'd0,
      PK_BLANK   = 2'd1,
      PK_MINUS   = 2'd2,
      PK_ILLEGAL = 2'd3
   } pat_kind_e;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational classifier for one segment pattern (dp already stripped).
// The minus pattern is only recognised when SEG_DEC_SIGN_EN is defined.
module seg_pattern_decode
   import seg_dec_pkg::*;
(
   input  logic [6:0] seg_i,
   output logic [1:0] kind_o,
   output logic [3:0] bcd_o
);

   always_comb begin
      kind_o = PK_DIGIT;
      bcd_o  = 4'd0;
      // Force dp off so the comparison uses the canonical pattern constants.
      unique case ({1'b1, seg_i})
         SEG_D0:    bcd_o = 4'd0;
         SEG_D1:    bcd_o = 4'd1;
         SEG_D2:    bcd_o = 4'd2;
         SEG_D3:    bcd_o = 4'd3;
         SEG_D4:    bcd_o = 4'd4;
         SEG_D5:    bcd_o = 4'd5;
         SEG_D6:    bcd_o = 4'd6;
         SEG_D7:    bcd_o = 4'd7;
         SEG_D8:    bcd_o = 4'd8;
         SEG_D9:    bcd_o = 4'd9;
         SEG_BLANK: kind_o = PK_BLANK;
`ifdef SEG_DEC_SIGN_EN
         SEG_MINUS: kind_o = PK_MINUS;
`endif
         default:   kind_o = PK_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/seg_frame_decoder.sv
// Decodes a frame of NUM_DIGITS seven-segment beats (MSD first) into a binary value
// with valid/ready handoff. Define SEG_DEC_SIGN_EN to accept a leading minus sign.
module seg_frame_decoder
   import seg_dec_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 6,
   parameter int unsigned VAL_W      = 20
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seg_valid,
   output logic             seg_ready,
   input  logic             seg_first,
   input  logic [7:0]       seg_data,
   output logic             val_valid,
   input  logic             val_ready,
   output logic [VAL_W-1:0] val_data,
   output logic             val_blank,
   output logic             val_err,
   output logic             val_neg
);

   localparam int unsigned     CntW    = $clog2(NUM_DIGITS + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(NUM_DIGITS);

   logic [1:0]       state_q, state_d;
   logic [VAL_W-1:0] acc_q, acc_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             seen_q, seen_d;
   logic             err_q, err_d;
   logic             neg_q, neg_d;
   logic [VAL_W-1:0] val_data_q, val_data_d;
   logic             val_blank_q, val_blank_d;
   logic             val_err_q, val_err_d;
   logic             val_neg_q, val_neg_d;

   logic [1:0]       kind;
   logic [3:0]       bcd;
   logic             unused_dp;

   logic             beat, take;
   logic [VAL_W-1:0] base_acc, acc_x10, nxt_acc;
   logic [CntW-1:0]  base_cnt, nxt_cnt;
   logic             base_seen, base_err, base_neg;
   logic             nxt_seen, nxt_err, nxt_neg;

   assign unused_dp = seg_data[7];

   seg_pattern_decode u_decode (
      .seg_i  (seg_data[6:0]),
      .kind_o (kind),
      .bcd_o  (bcd)
   );

   assign seg_ready = (state_q != DONE);
   assign val_valid = (state_q == DONE);
   assign beat      = seg_valid && seg_ready;
   assign take      = beat && (seg_first || (state_q == COLLECT));

   // A seg_first beat always starts from a clean frame, discarding any partial one.
   always_comb begin
      base_acc  = seg_first ? '0 : acc_q;
      base_cnt  = seg_first ? '0 : cnt_q;
      base_seen = seg_first ? 1'b0 : seen_q;
      base_err  = seg_first ? 1'b0 : err_q;
      base_neg  = seg_first ? 1'b0 : neg_q;

      acc_x10  = (base_acc << 3) + (base_acc << 1);
      nxt_acc  = acc_x10 + {{(VAL_W-4){1'b0}}, bcd};
      nxt_cnt  = base_cnt + 1'b1;
      nxt_seen = base_seen | (kind == PK_DIGIT);
      nxt_neg  = base_neg | (kind == PK_MINUS);
      nxt_err  = base_err | (kind == PK_ILLEGAL) |
                 (base_seen && ((kind == PK_BLANK) || (kind == PK_MINUS)));
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      seen_d      = seen_q;
      err_d       = err_q;
      neg_d       = neg_q;
      val_data_d  = val_data_q;
      val_blank_d = val_blank_q;
      val_err_d   = val_err_q;
      val_neg_d   = val_neg_q;

      unique case (state_q)
         IDLE, COLLECT: begin
            if (take) begin
               if (nxt_cnt == LastCnt) begin
                  state_d     = DONE;
                  val_err_d   = nxt_err;
                  val_data_d  = nxt_err ? '0 : nxt_acc;
                  val_neg_d   = nxt_neg && !nxt_err;
                  val_blank_d = !nxt_err && !nxt_seen && !nxt_neg;
                  acc_d       = '0;
                  cnt_d       = '0;
                  seen_d      = 1'b0;
                  err_d       = 1'b0;
                  neg_d       = 1'b0;
               end else begin
                  state_d = COLLECT;
                  acc_d   = nxt_acc;
                  cnt_d   = nxt_cnt;
                  seen_d  = nxt_seen;
                  err_d   = nxt_err;
                  neg_d   = nxt_neg;
               end
            end
         end
         DONE: begin
            if (val_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         seen_q      <= 1'b0;
         err_q       <= 1'b0;
         neg_q       <= 1'b0;
         val_data_q  <= '0;
         val_blank_q <= 1'b0;
         val_err_q   <= 1'b0;
         val_neg_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         seen_q      <= seen_d;
         err_q       <= err_d;
         neg_q       <= neg_d;
         val_data_q  <= val_data_d;
         val_blank_q <= val_blank_d;
         val_err_q   <= val_err_d;
         val_neg_q   <= val_neg_d;
      end
   end

   assign val_data  = val_data_q;
   assign val_blank = val_blank_q;
   assign val_err   = val_err_q;
   assign val_neg   = val_neg_q;

endmodule

// File: tb/tb_seg_frame_decoder.sv
// Self-checking bench for seg_frame_decoder: directed frames plus randomized frames
// checked against a digit-weight reference model.
module tb_seg_frame_decoder;

   localparam int NumDig = 6;
`ifdef SEG_DEC_SIGN_EN
   localparam bit SignEn = 1'b1;
`else
   localparam bit SignEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        seg_valid, seg_ready, seg_first;
   logic [7:0]  seg_data;
   logic        val_valid, val_ready;
   logic [19:0] val_data;
   logic        val_blank, val_err, val_neg;

   always #5 clk = ~clk;

   seg_frame_decoder #(.NUM_DIGITS(NumDig), .VAL_W(20)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .seg_valid (seg_valid),
      .seg_ready (seg_ready),
      .seg_first (seg_first),
      .seg_data  (seg_data),
      .val_valid (val_valid),
      .val_ready (val_ready),
      .val_data  (val_data),
      .val_blank (val_blank),
      .val_err   (val_err),
      .val_neg   (val_neg)
   );

   int n_cmp  = 0;
   int n_fail = 0;
   int hs_cnt = 0;

   logic [7:0] num_pat [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

   always @(posedge clk) if (val_valid && val_ready) hs_cnt <= hs_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: value is the sum of digit * 10^position; leading blanks/minus are zero.
   task automatic model(input logic [7:0] f [NumDig], output int v, output bit bl,
                        output bit er, output bit ng);
      bit any_num;
      int weight;
      int d;
      logic [7:0] p;
      v = 0; er = 0; ng = 0; any_num = 0;
      for (int i = 0; i < NumDig; i++) begin
         p = f[i] | 8'h80;
         d = -1;
         for (int k = 0; k < 10; k++) if (p == num_pat[k]) d = k;
         weight = 1;
         for (int j = i + 1; j < NumDig; j++) weight = weight * 10;
         if (d >= 0) begin
            any_num = 1;
            v = v + d * weight;
         end else if (p == 8'hFF) begin
            if (any_num) er = 1;
         end else if (SignEn && p == 8'hBF && !any_num) begin
            ng = 1;
         end else begin
            er = 1;
         end
      end
      bl = !er && !any_num && !ng;
      if (er) begin
         v  = 0;
         ng = 0;
      end
   endtask

   task automatic drive_beat(input logic [7:0] d, input bit first);
      int n = 0;
      @(negedge clk);
      seg_valid = 1'b1;
      seg_data  = d;
      seg_first = first;
      while (!seg_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("seg_ready_timeout", 32'(n), 32'(0));
      @(posedge clk);
      #1;
      seg_valid = 1'b0;
      seg_first = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] f [NumDig]);
      for (int i = 0; i < NumDig; i++) drive_beat(f[i], i == 0);
   endtask

   task automatic get_result(input string tag, input int ev, input bit eb, input bit ee,
                             input bit en, input bit do_ack, input int ack_dly,
                             output int lat);
      int n = 0;
      @(negedge clk);
      while (!val_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      lat = n;
      chk({tag, "_valid"}, 32'(val_valid), 32'(1));
      chk({tag, "_data"},  32'(val_data),  32'(ev));
      chk({tag, "_blank"}, 32'(val_blank), 32'(eb));
      chk({tag, "_err"},   32'(val_err),   32'(ee));
      chk({tag, "_neg"},   32'(val_neg),   32'(en));
      if (do_ack) begin
         repeat (ack_dly) @(negedge clk);
         val_ready = 1'b1;
         @(posedge clk);
         #1;
         val_ready = 1'b0;
      end
   endtask

   logic [7:0] fr  [NumDig];
   logic [7:0] fr2 [NumDig];
   int  v, lat, lead, k, j, h0;
   bit  bl, er, ng;

   initial begin
      rst_n     = 1'b0;
      seg_valid = 1'b0;
      seg_first = 1'b0;
      seg_data  = 8'hFF;
      val_ready = 1'b0;
      #12;
      chk("rst_val_valid", 32'(val_valid), 32'(0));
      chk("rst_val_data",  32'(val_data),  32'(0));
      chk("rst_val_blank", 32'(val_blank), 32'(0));
      chk("rst_val_err",   32'(val_err),   32'(0));
      chk("rst_val_neg",   32'(val_neg),   32'(0));
      chk("rst_seg_ready", 32'(seg_ready), 32'(1));
      @(negedge clk);
      rst_n = 1'b1;

      fr = '{8'h82, 8'hF8, 8'h80, 8'h90, 8'hF9, 8'h92};
      send_frame(fr);
      get_result("f678915", 678915, 0, 0, 0, 1, 0, lat);
      chk("f678915_latency", 32'(lat), 32'(0));

      fr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hA4};
      send_frame(fr);
      get_result("lead_blank", 12, 0, 0, 0, 1, 0, lat);

      fr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      send_frame(fr);
      get_result("all_blank", 0, 1, 0, 0, 1, 1, lat);

      fr = '{8'hC0, 8'hF9, 8'hA5, 8'hC0, 8'hC0, 8'hC0};
      send_frame(fr);
      get_result("illegal", 0, 0, 1, 0, 1, 0, lat);

      fr = '{8'hF9, 8'hFF, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
      send_frame(fr);
      get_result("emb_blank", 0, 0, 1, 0, 1, 0, lat);

      // dp is masked: 8'h12 decodes as 5, 8'h10 as 9
      fr = '{8'h40, 8'h79, 8'h24, 8'h30, 8'h12, 8'h10};
      send_frame(fr);
      get_result("dp_mask", 12359, 0, 0, 0, 1, 0, lat);

      // Stray non-first beat in IDLE is dropped
      drive_beat(8'hF9, 1'b0);
      fr = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hA4};
      send_frame(fr);
      get_result("stray_drop", 2, 0, 0, 0, 1, 0, lat);

      // Restart mid-frame
      h0 = hs_cnt;
      drive_beat(8'h90, 1'b1);
      drive_beat(8'h90, 1'b0);
      drive_beat(8'hFF, 1'b0);
      fr = '{8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82};
      send_frame(fr);
      get_result("restart", 123456, 0, 0, 0, 1, 0, lat);
      @(negedge clk);
      chk("restart_one_pulse", 32'(hs_cnt - h0), 32'(1));
      chk("restart_valid_low", 32'(val_valid),   32'(0));

      // Backpressure: next frame's first beat waits while result is held
      fr  = '{8'hC0, 8'hC0, 8'hC0, 8'hB0, 8'hB0, 8'hB0};
      fr2 = '{8'h90, 8'h80, 8'hF8, 8'h82, 8'h92, 8'h99};
      send_frame(fr);
      get_result("bp_a", 333, 0, 0, 0, 0, 0, lat);
      seg_valid = 1'b1;
      seg_first = 1'b1;
      seg_data  = fr2[0];
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("bp_seg_ready", 32'(seg_ready), 32'(0));
         chk("bp_valid",     32'(val_valid), 32'(1));
         chk("bp_hold_data", 32'(val_data),  32'(333));
      end
      val_ready = 1'b1;
      @(posedge clk);
      #1;
      val_ready = 1'b0;
      send_frame(fr2);
      get_result("bp_b", 987654, 0, 0, 0, 1, 0, lat);

      // Sign frame
      fr = '{8'hBF, 8'hFF, 8'hFF, 8'hFF, 8'hF9, 8'hC0};
      send_frame(fr);
      get_result("sign", SignEn ? 10 : 0, 0, !SignEn, SignEn, 1, 0, lat);

      // Minus after a numeral is always an error
      fr = '{8'hF9, 8'hBF, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
      send_frame(fr);
      get_result("late_minus", 0, 0, 1, 0, 1, 0, lat);

      // Asynchronous reset mid-frame
      fr = '{8'h99, 8'h99, 8'h99, 8'h99, 8'h99, 8'h99};
      send_frame(fr);
      get_result("pre_reset", 444444, 0, 0, 0, 1, 0, lat);
      drive_beat(8'hF9, 1'b1);
      drive_beat(8'hA4, 1'b0);
      drive_beat(8'hB0, 1'b0);
      @(negedge clk);
      chk("pre_reset_data", 32'(val_data), 32'(444444));
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_val_data",  32'(val_data),  32'(0));
      chk("arst_val_valid", 32'(val_valid), 32'(0));
      chk("arst_seg_ready", 32'(seg_ready), 32'(1));
      @(negedge clk);
      rst_n = 1'b1;
      // A continuation beat after reset must be dropped, not finish the old frame
      drive_beat(8'h99, 1'b0);
      drive_beat(8'h99, 1'b0);
      drive_beat(8'h99, 1'b0);
      fr = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h80};
      send_frame(fr);
      get_result("post_reset", 8, 0, 0, 0, 1, 0, lat);

      // Randomized frames
      for (int t = 0; t < 40; t++) begin
         if ($urandom_range(0, 5) == 0) drive_beat(8'($urandom), 1'b0);
         if ($urandom_range(0, 5) == 0) begin
            k = $urandom_range(1, NumDig - 2);
            for (int i = 0; i < k; i++) drive_beat(8'($urandom), i == 0);
         end
         lead = $urandom_range(0, NumDig);
         for (int i = 0; i < NumDig; i++) begin
            if (i < lead) fr[i] = (i == 0 && $urandom_range(0, 2) == 0) ? 8'hBF : 8'hFF;
            else          fr[i] = num_pat[$urandom_range(0, 9)];
         end
         if ($urandom_range(0, 3) == 0) begin
            j = $urandom_range(0, NumDig - 1);
            fr[j] = 8'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            j = $urandom_range(0, NumDig - 1);
            fr[j] = fr[j] & 8'h7F;
         end
         model(fr, v, bl, er, ng);
         send_frame(fr);
         get_result("rand", v, bl, er, ng, 1, $urandom_range(0, 3), lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
